// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a single-ported, doubleword-wide
// data memory. Sub-doubleword stores are done as read-modify-write, and
// misaligned accesses are answered with an error without touching memory.
// The byte-lane logic assumes BITS = 64 (eight lanes selected by addr[2:0]).
module load_store_unit #(
    parameter int BITS        = 64,
    parameter int D_ADDR_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [D_ADDR_BITS-1:0] req_addr,
    input  logic [BITS-1:0]        req_wdata,
    output logic                   resp_valid,
    output logic [BITS-1:0]        resp_rdata,
    output logic                   resp_err,
    output logic [D_ADDR_BITS-4:0] mem_addr,
    output logic                   mem_we,
    output logic [BITS-1:0]        mem_din,
    input  logic [BITS-1:0]        mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic                   op_we;
    logic [1:0]             op_size;
    logic                   op_unsigned;
    logic [2:0]             op_off;
    logic [D_ADDR_BITS-4:0] op_index;
    logic [BITS-1:0]        op_wdata;
    logic                   op_err;
    logic [BITS-1:0]        word_q;

    logic                   handshake;
    logic                   misaligned;
    logic [7:0]             size_lanes;
    logic [7:0]             lane_mask;
    logic [BITS-1:0]        bit_mask;
    logic [BITS-1:0]        shifted_wdata;
    logic [BITS-1:0]        merged_word;
    logic [BITS-1:0]        shifted_word;
    logic [BITS-1:0]        load_value;

    assign handshake = req_valid && req_ready;

    // Alignment check on the incoming request, by access size.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // State register; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request fields on the handshake so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_we       <= 1'b0;
            op_size     <= 2'b00;
            op_unsigned <= 1'b0;
            op_off      <= 3'd0;
            op_index    <= '0;
            op_wdata    <= '0;
            op_err      <= 1'b0;
        end else if (handshake) begin
            op_we       <= req_we;
            op_size     <= req_size;
            op_unsigned <= req_unsigned;
            op_off      <= req_addr[2:0];
            op_index    <= req_addr[D_ADDR_BITS-1:3];
            op_wdata    <= req_wdata;
            op_err      <= misaligned;
        end
    end

    // Capture the addressed memory word while in READ (load data or RMW base).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (state == READ) begin
            word_q <= mem_dout;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (req_we && (req_size == 2'b11)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = op_we ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte-lane merge for stores and lane extraction plus extension for loads.
    always_comb begin
        size_lanes = 8'h00;
        case (op_size)
            2'b00:   size_lanes = 8'h01;
            2'b01:   size_lanes = 8'h03;
            2'b10:   size_lanes = 8'h0F;
            default: size_lanes = 8'hFF;
        endcase
        lane_mask = size_lanes << op_off;
        bit_mask  = '0;
        for (int k = 0; k < 8; k++) begin
            bit_mask[8*k +: 8] = {8{lane_mask[k]}};
        end
        shifted_wdata = op_wdata << {op_off, 3'b000};
        merged_word   = (word_q & ~bit_mask) | (shifted_wdata & bit_mask);

        shifted_word = word_q >> {op_off, 3'b000};
        load_value   = shifted_word;
        case (op_size)
            2'b00:   load_value = {{(BITS-8){~op_unsigned & shifted_word[7]}}, shifted_word[7:0]};
            2'b01:   load_value = {{(BITS-16){~op_unsigned & shifted_word[15]}}, shifted_word[15:0]};
            2'b10:   load_value = {{(BITS-32){~op_unsigned & shifted_word[31]}}, shifted_word[31:0]};
            default: load_value = shifted_word;
        endcase
    end

    // Outputs decoded from the current state; mem_we is gated by reset directly.
    always_comb begin
        req_ready  = (state == IDLE) && rst_n;
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && op_err;
        resp_rdata = '0;
        if ((state == RESP) && !op_we && !op_err) begin
            resp_rdata = load_value;
        end
        mem_addr = (state == IDLE) ? req_addr[D_ADDR_BITS-1:3] : op_index;
        mem_we   = (state == WRITE) && rst_n;
        mem_din  = mem_we ? merged_word : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized accesses,
// checked against a byte-addressed reference memory model.
module tb_load_store_unit;

    localparam int BITS        = 64;
    localparam int D_ADDR_BITS = 8;
    localparam int WORDS       = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;

    logic [63:0] tb_mem [WORDS];
    logic [7:0]  ref_mem [256];
    logic        bk_we;
    logic [4:0]  bk_addr;
    logic [63:0] bk_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .BITS        (BITS),
        .D_ADDR_BITS (D_ADDR_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    assign mem_dout = tb_mem[mem_addr];

    // Data memory: DUT writes on the rising edge; the bench preloads through bk_*.
    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_din;
        end else if (bk_we) begin
            tb_mem[bk_addr] <= bk_data;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic we, input logic [1:0] size,
                                  input logic uns, input logic [7:0] addr, input logic [63:0] wdata);
        req_valid    = valid;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic apply_random_fields(input logic valid);
        apply_stimulus(valid, 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), {$urandom, $urandom});
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            v[8*i +: 8] = ref_mem[8*w + i];
        end
        return v;
    endfunction

    task automatic set_word(input int w, input logic [63:0] val);
        @(negedge clk);
        bk_we   = 1'b1;
        bk_addr = 5'(w);
        bk_data = val;
        @(posedge clk);
        #1;
        bk_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ref_mem[8*w + i] = val[8*i +: 8];
        end
    endtask

    // Reference behaviour: byte-addressed memory, little-endian, natural alignment.
    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [7:0] addr, input logic [63:0] wdata,
                                output logic [63:0] rdata, output logic err,
                                output int lat, output int we_cycle);
        int n;
        n        = 1 << size;
        rdata    = '0;
        err      = 1'b0;
        lat      = 0;
        we_cycle = 0;
        if ((int'(addr) % n) != 0) begin
            err = 1'b1;
            lat = 1;
        end else if (!we) begin
            for (int i = 0; i < n; i++) begin
                rdata[8*i +: 8] = ref_mem[int'(addr) + i];
            end
            if (!uns && (n < 8) && rdata[8*n-1]) begin
                rdata = rdata | ~((64'd1 << (8*n)) - 64'd1);
            end
            lat = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            end
            lat      = (n == 8) ? 2 : 3;
            we_cycle = lat - 1;
        end
    endtask

    // One complete access, compared in every respect against the reference model.
    task automatic run_access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                              input logic [7:0] addr, input logic [63:0] wdata, output logic [63:0] got_rdata);
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        got_err;
        int          exp_lat, exp_we_cycle, lat, we_count, we_cycle, cyc;
        bit          ready_bad, din_bad, addr_bad;
        model_access(we, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat, exp_we_cycle);
        got_rdata = '0;
        got_err   = 1'b0;
        lat       = 0;
        we_count  = 0;
        we_cycle  = 0;
        cyc       = 0;
        ready_bad = 0;
        din_bad   = 0;
        addr_bad  = 0;
        @(negedge clk);
        apply_stimulus(1'b1, we, size, uns, addr, wdata);
        #1;
        check_output({tag, "_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        while (lat == 0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (mem_we) begin
                we_count++;
                we_cycle = cyc;
            end else if (mem_din !== '0) begin
                din_bad = 1;
            end
            if (req_ready) ready_bad = 1;
            if (resp_valid) begin
                lat       = cyc;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                apply_random_fields(1'b0);
            end else begin
                if (mem_addr !== addr[7:3]) addr_bad = 1;
                apply_random_fields(1'b1);
            end
        end
        if (lat == 0) apply_random_fields(1'b0);
        check_output({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_output({tag, "_err"}, 64'(got_err), 64'(exp_err));
        check_output({tag, "_rdata"}, got_rdata, exp_rdata);
        check_output({tag, "_we_count"}, 64'(we_count), (exp_we_cycle != 0) ? 64'd1 : 64'd0);
        check_output({tag, "_we_cycle"}, 64'(we_cycle), 64'(exp_we_cycle));
        check_output({tag, "_din_idle"}, 64'(din_bad), 64'd0);
        check_output({tag, "_ready_busy"}, 64'(ready_bad), 64'd0);
        check_output({tag, "_mem_addr"}, 64'(addr_bad), 64'd0);
        check_output({tag, "_mem_word"}, tb_mem[addr[7:3]], ref_word(int'(addr[7:3])));
        @(negedge clk);
        check_output({tag, "_post_valid"}, 64'(resp_valid), 64'd0);
        check_output({tag, "_post_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat, exp_we_cycle, cyc, first_resp, lat;
        bit          resp_seen;
        logic [7:0]  a;
        logic [1:0]  sz;

        // Reset and memory preload
        rst_n = 1'b0;
        bk_we = 1'b0;
        bk_addr = '0;
        bk_data = '0;
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 64'h0);
        for (int w = 0; w < WORDS; w++) begin
            set_word(w, {$urandom, $urandom});
        end
        @(negedge clk);
        check_output("reset_ready", 64'(req_ready), 64'd0);
        check_output("reset_resp_valid", 64'(resp_valid), 64'd0);
        check_output("reset_resp_err", 64'(resp_err), 64'd0);
        check_output("reset_resp_rdata", resp_rdata, 64'd0);
        check_output("reset_mem_we", 64'(mem_we), 64'd0);
        rst_n = 1'b1;
        #1;
        check_output("release_ready", 64'(req_ready), 64'd1);

        // Doubleword load of a known word
        set_word(6, 64'h33);
        run_access("ld_0x30", 1'b0, 2'b11, 1'b0, 8'h30, 64'h0, got);
        check_output("ld_0x30_value", got, 64'h33);

        // Signed and unsigned byte loads of a negative byte
        set_word(2, 64'h0000_0000_0000_80FF);
        run_access("lb_0x11", 1'b0, 2'b00, 1'b0, 8'h11, 64'h0, got);
        check_output("lb_0x11_value", got, 64'hFFFF_FFFF_FFFF_FF80);
        run_access("lbu_0x11", 1'b0, 2'b00, 1'b1, 8'h11, 64'h0, got);
        check_output("lbu_0x11_value", got, 64'h80);

        // Halfword read-modify-write store into lanes 3:2
        set_word(5, 64'h12);
        run_access("sh_0x2a", 1'b1, 2'b01, 1'b0, 8'h2A, 64'hFFFF_0000_0000_ABCD, got);
        check_output("sh_0x2a_word", tb_mem[5], 64'h0000_0000_ABCD_0012);

        // Misaligned accesses
        run_access("lw_0x0e", 1'b0, 2'b10, 1'b0, 8'h0E, 64'h0, got);
        run_access("sd_0x19", 1'b1, 2'b11, 1'b0, 8'h19, 64'hDEAD_BEEF_0000_1111, got);

        // Reset asserted during the WRITE cycle of a byte store
        set_word(1, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0, 8'h08, 64'h7F);
        #1;
        check_output("rstwr_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        check_output("rstwr_in_write", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check_output("rstwr_we_gated", 64'(mem_we), 64'd0);
        check_output("rstwr_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("rstwr_resp_valid", 64'(resp_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        check_output("rstwr_ready_after", 64'(req_ready), 64'd1);
        resp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) resp_seen = 1;
        end
        check_output("rstwr_no_resp", 64'(resp_seen), 64'd0);
        check_output("rstwr_word1", tb_mem[1], 64'h0123_4567_89AB_CDEF);

        // Back-to-back store then load with req_valid held high
        model_access(1'b1, 2'b11, 1'b0, 8'h00, 64'h1122, exp_rdata, exp_err, exp_lat, exp_we_cycle);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 2'b11, 1'b0, 8'h00, 64'h1122);
        #1;
        check_output("b2b_first_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        cyc = 0;
        first_resp = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) apply_stimulus(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, {$urandom, $urandom});
            #1;
            if (resp_valid && first_resp == 0) first_resp = cyc;
        end while (!req_ready && cyc < 8);
        check_output("b2b_first_resp", 64'(first_resp), 64'd2);
        check_output("b2b_second_ready", 64'(cyc), 64'd3);
        model_access(1'b0, 2'b11, 1'b0, 8'h00, 64'h0, exp_rdata, exp_err, exp_lat, exp_we_cycle);
        @(posedge clk);
        lat = 0;
        cyc = 0;
        got = '0;
        while (lat == 0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = cyc;
                got = resp_rdata;
            end
        end
        check_output("b2b_ld_latency", 64'(lat), 64'(exp_lat));
        check_output("b2b_ld_rdata", got, exp_rdata);
        check_output("b2b_ld_value", got, 64'h1122);
        check_output("b2b_word0", tb_mem[0], ref_word(0));

        // Randomized accesses, mostly aligned
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom);
            a  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
            run_access("rnd", 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, got);
        end

        // Final full-memory comparison against the model
        for (int w = 0; w < WORDS; w++) begin
            check_output("final_mem", tb_mem[w], ref_word(w));
        end

        $display("[TB] done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
